// File: rtl/chip_test_sequencer.sv
// Runs one chip tester per accepted Start (Run pulse, wait for Done, capture RSLT, release via DISP_RSLT) and tallies results.
// Run is issued 1 cycle after Start and waits up to TIMEOUT_CYCLES for Done; Start is ignored while Busy.
`timescale 1ns/1ps
module chip_test_sequencer #(
   parameter int NUM_CHIPS      = 8,
   parameter int SEL_W          = 3,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [SEL_W-1:0]     Chip_Sel,
   input  logic                 Clear_Counts,
   output logic [NUM_CHIPS-1:0] Run_Vec,
   input  logic [NUM_CHIPS-1:0] Done_Vec,
   input  logic [NUM_CHIPS-1:0] RSLT_Vec,
   output logic                 DISP_RSLT,
   output logic                 Busy,
   output logic                 Result_Valid,
   output logic                 Pass,
   output logic                 Timeout,
   output logic                 Sel_Err,
   output logic [7:0]           Pass_Count,
   output logic [7:0]           Fail_Count
);

   localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_DONE, SETTLE, ACK, ABORT} state_t;

   state_t               state;
   state_t               state_nxt;
   logic                 start_q;
   logic                 start_edge;
   logic                 sel_bad;
   logic [SEL_W-1:0]     sel;
   logic [NUM_CHIPS-1:0] sel_oh;
   logic                 done_sel;
   logic                 rslt_sel;
   logic [TO_W-1:0]      to_cnt;
   logic                 to_hit;

   logic                 accept;
   logic                 wait_to;
   logic                 capture;
   logic                 ack_to;
   logic                 cnt_clr;
   logic                 cnt_run;
   logic                 pass_inc;
   logic                 fail_inc;

   // Unselected testers are masked out; an out-of-range sel shifts to an all-zero mask.
   assign sel_oh     = NUM_CHIPS'(1) << sel;
   assign done_sel   = |(Done_Vec & sel_oh);
   assign rslt_sel   = |(RSLT_Vec & sel_oh);
   assign start_edge = Start & ~start_q;
   assign sel_bad    = int'(Chip_Sel) >= NUM_CHIPS;
   assign to_hit     = (to_cnt == TO_LAST);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start_edge) state_nxt = sel_bad ? IDLE : LAUNCH;
         LAUNCH:    state_nxt = WAIT_DONE;
         WAIT_DONE: begin
            if (done_sel)    state_nxt = SETTLE;
            else if (to_hit) state_nxt = ABORT;
         end
         SETTLE:    state_nxt = ACK;
         ACK:       if (!done_sel || to_hit) state_nxt = IDLE;
         ABORT:     state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      Run_Vec   = '0;
      DISP_RSLT = 1'b0;
      Busy      = (state != IDLE);
      accept    = 1'b0;
      wait_to   = 1'b0;
      capture   = 1'b0;
      ack_to    = 1'b0;
      cnt_clr   = 1'b0;
      cnt_run   = 1'b0;
      case (state)
         IDLE:      accept = start_edge;
         LAUNCH: begin
            Run_Vec = sel_oh;
            cnt_clr = 1'b1;
         end
         WAIT_DONE: begin
            cnt_run = 1'b1;
            wait_to = !done_sel && to_hit;
         end
         SETTLE: begin
            capture = 1'b1;
            cnt_clr = 1'b1;
         end
         ACK: begin
            DISP_RSLT = done_sel;
            cnt_run   = 1'b1;
            ack_to    = done_sel && to_hit;
         end
         ABORT:     DISP_RSLT = 1'b1;
         default:   ;
      endcase
      pass_inc = capture && rslt_sel;
      fail_inc = (accept && sel_bad) || wait_to || (capture && !rslt_sel);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         start_q      <= 1'b1;
         sel          <= '0;
         to_cnt       <= '0;
         Result_Valid <= 1'b0;
         Pass         <= 1'b0;
         Timeout      <= 1'b0;
         Sel_Err      <= 1'b0;
      end else begin
         start_q <= Start;
         if (cnt_clr) begin
            to_cnt <= '0;
         end else if (cnt_run) begin
            to_cnt <= to_cnt + TO_W'(1);
         end
         if (accept) begin
            sel          <= Chip_Sel;
            Pass         <= 1'b0;
            Timeout      <= 1'b0;
            Sel_Err      <= sel_bad;
            Result_Valid <= sel_bad;
         end
         if (wait_to) begin
            Timeout      <= 1'b1;
            Pass         <= 1'b0;
            Result_Valid <= 1'b1;
         end
         if (capture) begin
            Pass         <= rslt_sel;
            Result_Valid <= 1'b1;
         end
         // A tester that never drops Done is flagged but not counted again.
         if (ack_to) begin
            Timeout <= 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         Pass_Count <= '0;
         Fail_Count <= '0;
      end else if (Clear_Counts) begin
         Pass_Count <= '0;
         Fail_Count <= '0;
      end else begin
         if (pass_inc && Pass_Count != 8'hFF) Pass_Count <= Pass_Count + 8'd1;
         if (fail_inc && Fail_Count != 8'hFF) Fail_Count <= Fail_Count + 8'd1;
      end
   end

endmodule
